instr_seq_ctrl: RTL

INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

---
 rtl/instr_seq_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WB, issues
// datapath strobes, counts retired instructions and traps illegal opcodes and memory timeouts.
module instr_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_start,
  input  logic        I_stop,
  input  logic [6:0]  I_op,
  input  logic        I_mem_ready,
  input  logic        I_br_taken,
  output logic        O_ifetch,
  output logic        O_ir_load,
  output logic        O_dec_en,
  output logic        O_alu_en,
  output logic        O_mem_rd,
  output logic        O_mem_wr,
  output logic        O_reg_wr,
  output logic        O_pc_en,
  output logic        O_pc_sel,
  output logic        O_busy,
  output logic        O_illegal,
  output logic        O_timeout,
  output logic [15:0] O_instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic [6:0]  op_q, op_d;
  logic        stop_q, stop_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic        retire;
  logic        stop_pend;
  logic        tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      op_q      <= '0;
      stop_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      stop_q    <= stop_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    stop_pend = stop_q | I_stop;
    // A ready arriving on the 255th count still wins over the timeout.
    tmo_hit   = (state_q == S_FETCH || state_q == S_MEM) && !I_mem_ready && (wait_q == 8'hFF);
    case (state_q)
      S_IDLE: begin
        if (I_start && !illegal_q && !timeout_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (I_mem_ready) state_d = S_DECODE;
        else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        op_d = I_op;
        case (I_op)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_IMM, OP_REG:    state_d = S_WB;
          OP_BRANCH:         retire  = 1'b1;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        if (I_mem_ready) begin
          if (op_q == OP_STORE) retire = 1'b1;
          else state_d = S_WB;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WB:    retire = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = stop_pend ? S_IDLE : S_FETCH;
    cnt_d  = cnt_q + {15'd0, retire};
    wait_d = ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q && !I_mem_ready)
             ? wait_q + 8'd1 : '0;
    stop_d = (state_q == S_IDLE || state_d == S_IDLE) ? 1'b0 : stop_pend;
  end

  always_comb begin
    O_ifetch  = 1'b0;
    O_ir_load = 1'b0;
    O_dec_en  = 1'b0;
    O_alu_en  = 1'b0;
    O_mem_rd  = 1'b0;
    O_mem_wr  = 1'b0;
    O_reg_wr  = 1'b0;
    O_pc_en   = 1'b0;
    O_pc_sel  = 1'b0;
    O_busy    = (state_q != S_IDLE);
    case (state_q)
      S_FETCH: begin
        O_ifetch  = !tmo_hit;
        O_mem_rd  = !tmo_hit;
        O_ir_load = I_mem_ready;
      end
      S_DECODE: O_dec_en = 1'b1;
      S_EXEC: begin
        O_alu_en = 1'b1;
        if (I_op == OP_BRANCH) begin
          O_pc_en  = 1'b1;
          O_pc_sel = I_br_taken;
        end
      end
      S_MEM: begin
        O_mem_wr = !tmo_hit && (op_q == OP_STORE);
        O_mem_rd = !tmo_hit && (op_q != OP_STORE);
        O_pc_en  = I_mem_ready && (op_q == OP_STORE);
      end
      S_WB: begin
        O_reg_wr = 1'b1;
        O_pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign O_illegal   = illegal_q;
  assign O_timeout   = timeout_q;
  assign O_instr_cnt = cnt_q;

endmodule
